e_mdu: RTL
==========

// Module: e_mdu
// PURPOSE
//  Execute-stage multiply/divide unit. Consumes the E-stage operands and instruction
//  class latched by the decode-to-execute pipeline register, and owns the HI/LO registers.
//  Models multi-cycle MULT/MULTU/DIV/DIVU latency with a busy counter. Drives the busy
//  indication that the hazard unit uses to stall MD-class instructions in D.
//  Suppresses architectural side effects when an exception request (Req) is raised.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high
//  Req         in   1   exception/interrupt request from the CP0 path; cancels the E-stage op this cycle
//  E_RD1       in   32  forwarded rs operand
//  E_RD2       in   32  forwarded rt operand
//  E_mdu_op    in   4   op code, MDU_* from the package; MDU_NONE=0 for nops and bubbles
//  E_busy      out  1   multi-cycle op in flight
//  E_mdu_stall out  1   E_busy | start accepted this cycle; D-stage MD instructions stall on this
//  E_mdu_out   out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
// BEHAVIOUR
//  Reset: HI=LO=0, cnt=0, shadow_hi=shadow_lo=0. E_busy=0, E_mdu_stall=0, E_mdu_out=0.
//  Reset wins over every other event in the same cycle.
//  Accepting a start:
//   - start = op in {MULT,MULTU,DIV,DIVU} & ~Req & ~E_busy.
//   - On accept, the result is computed from the operands at the edge into shadow regs.
//     cnt loads MULT_CYCLES or DIV_CYCLES.
//  Busy window:
//   - E_busy = (cnt!=0). cnt decrements each cycle. When cnt==1, HI/LO <= shadow.
//   - A start accepted at edge t gives E_busy high in cycles t+1..t+N.
//   - The new HI/LO is readable from cycle t+N+1.
//  Arithmetic:
//   - MULT: {HI,LO} = $signed(rs)*$signed(rt), full 64-bit. MULTU: same, unsigned.
//   - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
//   - DIVU: unsigned quotient and remainder.
//   - Divisor 0 (DIV or DIVU): the op still takes DIV_CYCLES, but HI and LO are left unchanged.
//  MTHI/MTLO:
//   - Write HI or LO <= rs at the edge when ~Req & ~E_busy. No busy period.
//  MFHI/MFLO:
//   - Read committed HI/LO combinationally. An MF op while busy is a hazard-unit error;
//     the assertion flags it and the read returns the stale value.
//  Req:
//   - Blocks start and MTHI/MTLO in the same cycle, so the pipeline register is flushing that op.
//   - An op already in flight belongs to an older, committed instruction: it completes and commits.
//  Boundaries:
//   - Start while E_busy: ignored, and the assertion flags it (the hazard unit must stall).
//   - Back-to-back: a start is accepted in the first cycle that E_busy=0, with no dead cycle.
//   - Reset mid-operation: cnt=0 and the pending result is discarded.
// STRUCTURE
//  Package mdu_pkg:
//   - MDU_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO encodings (4-bit).
//   - MULT_CYCLES and DIV_CYCLES default constants.
//  Sub-module mdu_datapath: combinational 64-bit product and quotient/remainder, with the
//  div-by-zero flag. e_mdu holds the counter, the shadow regs, HI/LO and the control.
// TESTING
//  1. MULT rs=0xFFFFFFFE, rt=3 -> E_busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. DIVU rs=100, rt=7 -> E_busy for 10 cycles, then LO=14, HI=2.
//     DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3. DIV rt=0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI and LO unchanged.
//     DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  4. MULT with Req=1 in the same cycle -> E_busy stays 0, HI/LO unchanged.
//     MTLO 0x5 with Req=1 -> LO unchanged.
//  5. Req=1 during cycle 3 of a MULT 4*5 -> still completes, LO=20, HI=0.
//  6. Reset in cycle 2 of a DIV -> E_busy=0 next cycle, HI=LO=0.
//     MTHI 0xABCD then MFHI -> E_mdu_out=0xABCD.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and latency defaults for the E-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  // True for the ops that occupy the unit for a busy window.
  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_datapath.sv
// Combinational arithmetic: 64-bit product and quotient/remainder.
// Division works on magnitudes so the 0x80000000 / -1 corner never hits a
// signed-overflow divide; the sign is reapplied afterwards.
module e_mdu_datapath
  import mdu_pkg::*;
(
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        mul_signed,
  input  logic        div_signed,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic [63:0] a_ext, b_ext;
  logic        rs_neg, rt_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  always_comb begin
    a_ext = mul_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
    b_ext = mul_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
    prod  = a_ext * b_ext;
  end

  // Magnitude divide, then restore signs: quotient truncates toward zero,
  // remainder takes the dividend's sign.
  always_comb begin
    div_zero = (rt == 32'd0);
    rs_neg   = div_signed & rs[31];
    rt_neg   = div_signed & rt[31];
    ua       = rs_neg ? (32'd0 - rs) : rs;
    ub       = rt_neg ? (32'd0 - rt) : rt;
    ub_safe  = div_zero ? 32'd1 : ub;
    uq       = ua / ub_safe;
    ur       = ua % ub_safe;
    quot     = (rs_neg ^ rt_neg) ? (32'd0 - uq) : uq;
    rem      = rs_neg ? (32'd0 - ur) : ur;
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, models op latency with a
// down-counter, and commits a shadowed result on the last busy cycle.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic [3:0]  E_mdu_op,
  output logic        E_busy,
  output logic        E_mdu_stall,
  output logic [31:0] E_mdu_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo, shadow_hi, shadow_lo;
  logic          shadow_wr;

  logic          is_md, is_mul, start, mt_en;
  logic [63:0]   prod;
  logic [31:0]   quot, rem;
  logic          div_zero;

  e_mdu_datapath u_dp (
    .rs         (E_RD1),
    .rt         (E_RD2),
    .mul_signed (E_mdu_op == MDU_MULT),
    .div_signed (E_mdu_op == MDU_DIV),
    .prod       (prod),
    .quot       (quot),
    .rem        (rem),
    .div_zero   (div_zero)
  );

  // Start / move-to qualification; Req flushes the E-stage op this cycle.
  always_comb begin
    is_md       = is_md_start_op(E_mdu_op);
    is_mul      = (E_mdu_op == MDU_MULT) || (E_mdu_op == MDU_MULTU);
    E_busy      = (cnt != '0);
    start       = is_md & ~Req & ~E_busy;
    mt_en       = ~Req & ~E_busy;
    E_mdu_stall = E_busy | start;
  end

  // Latency counter and shadow result; divide-by-zero runs the full window
  // but marks the shadow as non-committing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      shadow_wr <= 1'b0;
    end else if (start) begin
      cnt       <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      shadow_hi <= is_mul ? prod[63:32] : rem;
      shadow_lo <= is_mul ? prod[31:0]  : quot;
      shadow_wr <= is_mul | ~div_zero;
    end else if (E_busy) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Architectural HI/LO: commit on the last busy cycle, else accept MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (cnt == CW'(1)) begin
      if (shadow_wr) begin
        hi <= shadow_hi;
        lo <= shadow_lo;
      end
    end else if (mt_en) begin
      if (E_mdu_op == MDU_MTHI) hi <= E_RD1;
      if (E_mdu_op == MDU_MTLO) lo <= E_RD1;
    end
  end

  // Read port for MFHI/MFLO.
  always_comb begin
    E_mdu_out = 32'd0;
    if (E_mdu_op == MDU_MFHI) E_mdu_out = hi;
    if (E_mdu_op == MDU_MFLO) E_mdu_out = lo;
  end

  // The hazard unit must keep MD ops out of E while a multi-cycle op runs.
  a_no_start_busy: assert property (@(posedge clk) disable iff (reset)
    !(E_busy && is_md && !Req));
  a_no_mf_busy: assert property (@(posedge clk) disable iff (reset)
    !(E_busy && !Req && ((E_mdu_op == MDU_MFHI) || (E_mdu_op == MDU_MFLO))));

endmodule
